// File: rtl/lr_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lr_pkt_arbiter
// Description : Packet-level arbiter sharing the 134-bit LCM output datapath
//               between two requesters (port 0: UM passthrough stream,
//               port 1: locally generated stream such as beacon reports).
//               A request/grant handshake lets each source stream whole
//               packets uninterrupted. Output is registered (one cycle of
//               latency). Per-port packet counters plus saturating drop and
//               timeout counters are maintained.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               inX_req / inX_grant       - packet slot request / grant
//               inX_data_wr, inX_data     - flit strobe and flit ([133:132] hdr)
//               inX_data_valid(_wr)       - packet-valid flag and its strobe
//               out_data_wr, out_data     - forwarded flit strobe and flit
//               out_data_valid(_wr)       - forwarded valid flag and strobe
//               pkt_cnt0 / pkt_cnt1       - packets forwarded per port (wrap)
//               drop_cnt / timeout_cnt    - dropped flits / revoked grants (sat)
// Revision    : 1.0 - initial release
// ============================================================================
module lr_pkt_arbiter #(
    parameter int PRIO_MODE = 0,   // 0 = round-robin, 1 = port 1 strict priority
    parameter int TIMEOUT   = 16,  // cycles allowed to present the first flit (2..255)
    parameter int IPG       = 2    // idle cycles forced after each packet (0..15)
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         in0_req,
    output logic         in0_grant,
    input  logic         in0_data_wr,
    input  logic [133:0] in0_data,
    input  logic         in0_data_valid,
    input  logic         in0_data_valid_wr,

    input  logic         in1_req,
    output logic         in1_grant,
    input  logic         in1_data_wr,
    input  logic [133:0] in1_data,
    input  logic         in1_data_valid,
    input  logic         in1_data_valid_wr,

    output logic         out_data_wr,
    output logic [133:0] out_data,
    output logic         out_data_valid,
    output logic         out_data_valid_wr,

    output logic [31:0]  pkt_cnt0,
    output logic [31:0]  pkt_cnt1,
    output logic [15:0]  drop_cnt,
    output logic [15:0]  timeout_cnt
);

    localparam logic [1:0] c_HDR_FIRST = 2'b01;
    localparam logic [1:0] c_HDR_LAST  = 2'b10;
    localparam logic [7:0] c_TIMER_MAX = 8'(TIMEOUT - 1);
    // GAP counts down from IPG-1 to 0, so it lasts exactly IPG cycles.
    localparam logic [3:0] c_GAP_INIT  = 4'((IPG > 0) ? (IPG - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_grant;     // one-hot grant, bit X drives inX_grant
    logic        r_gport;     // index of the port currently (or last) granted
    logic        r_last;      // round-robin pointer: port that was served last
    logic [7:0]  r_timer;
    logic [3:0]  r_gap_cnt;

    state_t      w_state_nxt;
    logic [1:0]  w_grant_nxt;
    logic        w_gport_nxt;
    logic        w_last_nxt;
    logic [7:0]  w_timer_nxt;
    logic [3:0]  w_gap_nxt;
    logic        w_pick;
    logic        w_fwd;
    logic        w_bad_hdr;
    logic        w_pkt_done;
    logic        w_timeout_hit;

    // Granted-port view of the input streams.
    logic         w_g_wr;
    logic [133:0] w_g_data;
    logic         w_g_valid;
    logic         w_g_valid_wr;
    logic [1:0]   w_g_hdr;

    logic         w_drop0;
    logic         w_drop1;
    logic [1:0]   w_drop_add;
    logic [16:0]  w_drop_sum;

    assign w_g_wr       = r_gport ? in1_data_wr       : in0_data_wr;
    assign w_g_data     = r_gport ? in1_data          : in0_data;
    assign w_g_valid    = r_gport ? in1_data_valid    : in0_data_valid;
    assign w_g_valid_wr = r_gport ? in1_data_valid_wr : in0_data_valid_wr;
    assign w_g_hdr      = w_g_data[133:132];

    // Any flit on a port that does not currently hold the grant is discarded.
    // In WAIT a bad first header can coincide with such a drop, hence up to +2.
    assign w_drop0    = in0_data_wr & ~r_grant[0];
    assign w_drop1    = in1_data_wr & ~r_grant[1];
    assign w_drop_add = {1'b0, w_drop0} + {1'b0, w_drop1} + {1'b0, w_bad_hdr};
    assign w_drop_sum = {1'b0, drop_cnt} + {15'd0, w_drop_add};

    assign in0_grant = r_grant[0];
    assign in1_grant = r_grant[1];

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gport_nxt   = r_gport;
        w_last_nxt    = r_last;
        w_timer_nxt   = r_timer;
        w_gap_nxt     = r_gap_cnt;
        w_pick        = 1'b0;
        w_fwd         = 1'b0;
        w_bad_hdr     = 1'b0;
        w_pkt_done    = 1'b0;
        w_timeout_hit = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in0_req || in1_req) begin
                    if (in0_req && in1_req) begin
                        w_pick = (PRIO_MODE == 1) ? 1'b1 : ~r_last;
                    end else begin
                        w_pick = in1_req;
                    end
                    w_gport_nxt = w_pick;
                    w_grant_nxt = w_pick ? 2'b10 : 2'b01;
                    w_timer_nxt = 8'd0;
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (w_g_wr) begin
                    if (w_g_hdr == c_HDR_FIRST) begin
                        w_fwd       = 1'b1;
                        w_state_nxt = S_XFER;
                    end else begin
                        // Only a start-of-packet may open the transfer.
                        w_bad_hdr = 1'b1;
                    end
                end else if (r_timer == c_TIMER_MAX) begin
                    w_grant_nxt   = 2'b00;
                    w_timeout_hit = 1'b1;
                    w_last_nxt    = r_gport;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end

            S_XFER: begin
                if (w_g_wr) begin
                    w_fwd = 1'b1;
                    if (w_g_hdr == c_HDR_LAST) begin
                        w_grant_nxt = 2'b00;
                        w_pkt_done  = 1'b1;
                        w_last_nxt  = r_gport;
                        w_gap_nxt   = c_GAP_INIT;
                        w_state_nxt = (IPG > 0) ? S_GAP : S_IDLE;
                    end
                end
            end

            S_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
            end

            default: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_grant           <= 2'b00;
            r_gport           <= 1'b0;
            r_last            <= 1'b1;   // port 0 wins the first tie
            r_timer           <= 8'd0;
            r_gap_cnt         <= 4'd0;
            out_data_wr       <= 1'b0;
            out_data          <= '0;
            out_data_valid    <= 1'b0;
            out_data_valid_wr <= 1'b0;
            pkt_cnt0          <= 32'd0;
            pkt_cnt1          <= 32'd0;
            drop_cnt          <= 16'd0;
            timeout_cnt       <= 16'd0;
        end else begin
            r_state           <= w_state_nxt;
            r_grant           <= w_grant_nxt;
            r_gport           <= w_gport_nxt;
            r_last            <= w_last_nxt;
            r_timer           <= w_timer_nxt;
            r_gap_cnt         <= w_gap_nxt;
            // Non-forwarding cycles present an all-zero bubble.
            out_data_wr       <= w_fwd;
            out_data          <= w_fwd ? w_g_data : '0;
            out_data_valid    <= w_fwd & w_g_valid;
            out_data_valid_wr <= w_fwd & w_g_valid_wr;
            if (w_pkt_done && !r_gport) begin
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
            if (w_pkt_done && r_gport) begin
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
            end
            drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_timeout_hit && (timeout_cnt != 16'hFFFF)) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lr_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lr_pkt_arbiter
// Description : Directed self-checking bench for lr_pkt_arbiter. Instance A
//               uses round-robin, instance B strict port-1 priority; both
//               share the input stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lr_pkt_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in0_req, in0_data_wr, in0_data_valid, in0_data_valid_wr;
    logic [133:0] in0_data;
    logic         in1_req, in1_data_wr, in1_data_valid, in1_data_valid_wr;
    logic [133:0] in1_data;

    logic         a_in0_grant, a_in1_grant, a_out_wr, a_out_valid, a_out_valid_wr;
    logic [133:0] a_out_data;
    logic [31:0]  a_pkt_cnt0, a_pkt_cnt1;
    logic [15:0]  a_drop_cnt, a_timeout_cnt;

    logic         b_in0_grant, b_in1_grant, b_out_wr, b_out_valid, b_out_valid_wr;
    logic [133:0] b_out_data;
    logic [31:0]  b_pkt_cnt0, b_pkt_cnt1;
    logic [15:0]  b_drop_cnt, b_timeout_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int src0_idx, src1_idx, pkt_len;

    always #5 clk = ~clk;

    lr_pkt_arbiter #(.PRIO_MODE(0), .TIMEOUT(16), .IPG(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .in0_req(in0_req), .in0_grant(a_in0_grant), .in0_data_wr(in0_data_wr),
        .in0_data(in0_data), .in0_data_valid(in0_data_valid),
        .in0_data_valid_wr(in0_data_valid_wr),
        .in1_req(in1_req), .in1_grant(a_in1_grant), .in1_data_wr(in1_data_wr),
        .in1_data(in1_data), .in1_data_valid(in1_data_valid),
        .in1_data_valid_wr(in1_data_valid_wr),
        .out_data_wr(a_out_wr), .out_data(a_out_data), .out_data_valid(a_out_valid),
        .out_data_valid_wr(a_out_valid_wr),
        .pkt_cnt0(a_pkt_cnt0), .pkt_cnt1(a_pkt_cnt1),
        .drop_cnt(a_drop_cnt), .timeout_cnt(a_timeout_cnt)
    );

    lr_pkt_arbiter #(.PRIO_MODE(1), .TIMEOUT(16), .IPG(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .in0_req(in0_req), .in0_grant(b_in0_grant), .in0_data_wr(in0_data_wr),
        .in0_data(in0_data), .in0_data_valid(in0_data_valid),
        .in0_data_valid_wr(in0_data_valid_wr),
        .in1_req(in1_req), .in1_grant(b_in1_grant), .in1_data_wr(in1_data_wr),
        .in1_data(in1_data), .in1_data_valid(in1_data_valid),
        .in1_data_valid_wr(in1_data_valid_wr),
        .out_data_wr(b_out_wr), .out_data(b_out_data), .out_data_valid(b_out_valid),
        .out_data_valid_wr(b_out_valid_wr),
        .pkt_cnt0(b_pkt_cnt0), .pkt_cnt1(b_pkt_cnt1),
        .drop_cnt(b_drop_cnt), .timeout_cnt(b_timeout_cnt)
    );

    function automatic logic [133:0] make_flit(input logic [1:0] hdr, input int idx, input int port);
        return {hdr, 4'(port), 32'(idx), 32'hDEADBEEF ^ 32'(idx), 32'(port * 256 + idx), 32'h1234_5678};
    endfunction

    function automatic logic [1:0] hdr_of(input int idx, input int len);
        return (idx == 0) ? 2'b01 : ((idx == len - 1) ? 2'b10 : 2'b11);
    endfunction

    task automatic set_idle();
        in0_data_wr = 0; in0_data = '0; in0_data_valid = 0; in0_data_valid_wr = 0;
        in1_data_wr = 0; in1_data = '0; in1_data_valid = 0; in1_data_valid_wr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; in0_req = 0; in1_req = 0; set_idle();
        src0_idx = 0; src1_idx = 0;
        @(negedge clk);
        rst = 0;
    endtask

    // Reactive sources: stream a pkt_len-flit packet whenever granted.
    task automatic drive_src(input logic g0, input logic g1);
        logic [1:0] h;
        if (g0) begin
            h = hdr_of(src0_idx, pkt_len);
            in0_data = make_flit(h, src0_idx, 0);
            in0_data_wr = 1; in0_data_valid = (h == 2'b10); in0_data_valid_wr = (h == 2'b10);
            src0_idx = (h == 2'b10) ? 0 : src0_idx + 1;
        end else begin
            in0_data_wr = 0; in0_data_valid = 0; in0_data_valid_wr = 0;
        end
        if (g1) begin
            h = hdr_of(src1_idx, pkt_len);
            in1_data = make_flit(h, src1_idx, 1);
            in1_data_wr = 1; in1_data_valid = (h == 2'b10); in1_data_valid_wr = (h == 2'b10);
            src1_idx = (h == 2'b10) ? 0 : src1_idx + 1;
        end else begin
            in1_data_wr = 0; in1_data_valid = 0; in1_data_valid_wr = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({a_in0_grant, a_in1_grant, a_out_wr, a_out_valid, a_out_valid_wr} !== 5'b0) begin
            n_fail++; $display("FAIL reset_a_flags: got %b want 00000",
                {a_in0_grant, a_in1_grant, a_out_wr, a_out_valid, a_out_valid_wr});
        end
        n_checks++;
        if (a_out_data !== 134'd0) begin
            n_fail++; $display("FAIL reset_a_data: got %h want 0", a_out_data);
        end
        n_checks++;
        if ({a_pkt_cnt0, a_pkt_cnt1, a_drop_cnt, a_timeout_cnt} !== 96'd0) begin
            n_fail++; $display("FAIL reset_a_counters: got %h want 0",
                {a_pkt_cnt0, a_pkt_cnt1, a_drop_cnt, a_timeout_cnt});
        end
        n_checks++;
        if ({b_in0_grant, b_in1_grant, b_out_wr, b_pkt_cnt0, b_pkt_cnt1, b_drop_cnt, b_timeout_cnt} !== 99'd0) begin
            n_fail++; $display("FAIL reset_b_all: got nonzero want 0");
        end
    endtask

    task automatic test_single_packet();
        int cyc;
        logic [1:0] h;
        logic v;
        do_reset();
        in0_req = 1;
        @(negedge clk);
        // One edge after req is sampled in IDLE the grant must be up.
        n_checks++;
        if (a_in0_grant !== 1'b1 || a_in1_grant !== 1'b0) begin
            n_fail++; $display("FAIL single_grant_latency: got g0=%b g1=%b want g0=1 g1=0", a_in0_grant, a_in1_grant);
        end
        in0_req = 0;
        for (int i = 0; i < 13; i++) begin
            h = hdr_of(i, 13);
            v = (i == 12);
            in0_data = make_flit(h, i, 0); in0_data_wr = 1;
            in0_data_valid = v; in0_data_valid_wr = v;
            @(negedge clk);
            n_checks++;
            if ({a_out_wr, a_out_valid, a_out_valid_wr, a_out_data} !== {1'b1, v, v, make_flit(h, i, 0)}) begin
                n_fail++; $display("FAIL single_flit_%0d: got wr=%b v=%b vw=%b d=%h want wr=1 v=%b vw=%b d=%h",
                    i, a_out_wr, a_out_valid, a_out_valid_wr, a_out_data, v, v, make_flit(h, i, 0));
            end
        end
        set_idle();
        n_checks++;
        if (a_in0_grant !== 1'b0) begin
            n_fail++; $display("FAIL single_grant_drop: got %b want 0", a_in0_grant);
        end
        n_checks++;
        if (a_pkt_cnt0 !== 32'd1) begin
            n_fail++; $display("FAIL single_pkt_cnt0: got %0d want 1", a_pkt_cnt0);
        end
        @(negedge clk);
        n_checks++;
        if (a_out_wr !== 1'b0 || a_out_data !== 134'd0) begin
            n_fail++; $display("FAIL single_bubble: got wr=%b d=%h want wr=0 d=0", a_out_wr, a_out_data);
        end
        cyc = 0;
    endtask

    task automatic test_round_robin();
        int ports[$];
        int gap;
        int cyc;
        do_reset();
        pkt_len = 3;
        in0_req = 1; in1_req = 1;
        gap = -1; cyc = 0;
        while ((a_pkt_cnt0 + a_pkt_cnt1) < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (a_out_wr === 1'b1) begin
                if (a_out_data[133:132] == 2'b01) begin
                    if (ports.size() > 0) begin
                        n_checks++;
                        if (gap !== 3) begin
                            n_fail++; $display("FAIL rr_gap_%0d: got %0d idle cycles want 3", ports.size(), gap);
                        end
                    end
                    ports.push_back(int'(a_out_data[131:128]));
                end
                if (a_out_data[133:132] == 2'b10) gap = 0;
            end else if (gap >= 0) begin
                gap++;
            end
            drive_src(a_in0_grant, a_in1_grant);
        end
        in0_req = 0; in1_req = 0; set_idle();
        n_checks++;
        if (cyc >= 200) begin
            n_fail++; $display("FAIL rr_timeout: got %0d cycles want < 200", cyc);
        end
        n_checks++;
        if (ports.size() != 4) begin
            n_fail++; $display("FAIL rr_pkt_count: got %0d packets want 4", ports.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (ports[i] != (i % 2)) begin
                    n_fail++; $display("FAIL rr_order_%0d: got port %0d want %0d", i, ports[i], i % 2);
                end
            end
        end
        n_checks++;
        if (a_pkt_cnt0 !== 32'd2 || a_pkt_cnt1 !== 32'd2) begin
            n_fail++; $display("FAIL rr_pkt_cnts: got %0d/%0d want 2/2", a_pkt_cnt0, a_pkt_cnt1);
        end
    endtask

    task automatic test_priority();
        int cyc;
        logic saw_g0;
        do_reset();
        pkt_len = 3;
        in0_req = 1; in1_req = 1;
        saw_g0 = 0; cyc = 0;
        while (b_pkt_cnt1 < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (b_in0_grant === 1'b1) saw_g0 = 1;
            drive_src(b_in0_grant, b_in1_grant);
        end
        n_checks++;
        if (saw_g0 !== 1'b0 || b_pkt_cnt0 !== 32'd0 || b_pkt_cnt1 !== 32'd3) begin
            n_fail++; $display("FAIL prio_port1_only: got saw_g0=%b cnt0=%0d cnt1=%0d want 0/0/3",
                saw_g0, b_pkt_cnt0, b_pkt_cnt1);
        end
        in1_req = 0;
        cyc = 0;
        while (b_in0_grant !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            drive_src(b_in0_grant, b_in1_grant);
        end
        n_checks++;
        if (b_in0_grant !== 1'b1) begin
            n_fail++; $display("FAIL prio_port0_after: got %b want 1", b_in0_grant);
        end
        in0_req = 0; set_idle();
    endtask

    task automatic test_timeout();
        int cyc;
        int cnt;
        do_reset();
        in1_req = 1;
        cyc = 0;
        while (a_in1_grant !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        in1_req = 0;
        cnt = 0;
        while (a_in1_grant === 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
        n_checks++;
        if (cnt != 16) begin
            n_fail++; $display("FAIL timeout_grant_cycles: got %0d want 16", cnt);
        end
        n_checks++;
        if (a_timeout_cnt !== 16'd1 || a_drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL timeout_cnt: got %0d drop %0d want 1 drop 0", a_timeout_cnt, a_drop_cnt);
        end
        in0_req = 1; in1_req = 1;
        cyc = 0;
        while (a_in0_grant !== 1'b1 && a_in1_grant !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        n_checks++;
        if (a_in0_grant !== 1'b1 || a_in1_grant !== 1'b0) begin
            n_fail++; $display("FAIL timeout_next_tie: got g0=%b g1=%b want g0=1 g1=0", a_in0_grant, a_in1_grant);
        end
        in0_req = 0; in1_req = 0;
    endtask

    task automatic test_drop();
        int cyc;
        logic [1:0] h;
        do_reset();
        in0_req = 1;
        cyc = 0;
        while (a_in0_grant !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        in0_req = 0;
        for (int i = 0; i < 5; i++) begin
            h = hdr_of(i, 5);
            in0_data = make_flit(h, i, 0); in0_data_wr = 1;
            in1_data = make_flit(2'b01, i, 1); in1_data_wr = (i >= 1 && i <= 3);
            @(negedge clk);
            n_checks++;
            if (a_out_wr !== 1'b1 || a_out_data !== make_flit(h, i, 0)) begin
                n_fail++; $display("FAIL drop_fwd_%0d: got wr=%b d=%h want wr=1 d=%h",
                    i, a_out_wr, a_out_data, make_flit(h, i, 0));
            end
        end
        set_idle();
        @(negedge clk);
        n_checks++;
        if (a_drop_cnt !== 16'd3 || a_pkt_cnt0 !== 32'd1) begin
            n_fail++; $display("FAIL drop_cnt: got drop %0d pkt0 %0d want 3 and 1", a_drop_cnt, a_pkt_cnt0);
        end
    endtask

    task automatic test_bad_header();
        int cyc;
        do_reset();
        in0_req = 1;
        cyc = 0;
        while (a_in0_grant !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        in0_req = 0;
        // Bad first header on the granted port plus an ungranted flit: +2.
        in0_data = make_flit(2'b11, 0, 0); in0_data_wr = 1;
        in1_data = make_flit(2'b01, 0, 1); in1_data_wr = 1;
        @(negedge clk);
        n_checks++;
        if (a_out_wr !== 1'b0 || a_drop_cnt !== 16'd2 || a_in0_grant !== 1'b1) begin
            n_fail++; $display("FAIL badhdr_dual: got wr=%b drop=%0d g0=%b want 0/2/1", a_out_wr, a_drop_cnt, a_in0_grant);
        end
        in1_data_wr = 0;
        in0_data = make_flit(2'b10, 1, 0);
        @(negedge clk);
        n_checks++;
        if (a_out_wr !== 1'b0 || a_drop_cnt !== 16'd3 || a_in0_grant !== 1'b1) begin
            n_fail++; $display("FAIL badhdr_single: got wr=%b drop=%0d g0=%b want 0/3/1", a_out_wr, a_drop_cnt, a_in0_grant);
        end
        in0_data = make_flit(2'b01, 2, 0);
        @(negedge clk);
        in0_data = make_flit(2'b10, 3, 0);
        @(negedge clk);
        set_idle();
        n_checks++;
        if (a_out_data !== make_flit(2'b10, 3, 0) || a_pkt_cnt0 !== 32'd1 || a_in0_grant !== 1'b0) begin
            n_fail++; $display("FAIL badhdr_recover: got d=%h pkt0=%0d g0=%b want last flit/1/0",
                a_out_data, a_pkt_cnt0, a_in0_grant);
        end
    endtask

    task automatic test_reset_mid_packet();
        int cyc;
        do_reset();
        pkt_len = 3;
        in0_req = 1;
        cyc = 0;
        while (a_in0_grant !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        in0_req = 0;
        for (int i = 0; i < 3; i++) begin
            in0_data = make_flit(hdr_of(i, 3), i, 0); in0_data_wr = 1;
            in1_data_wr = (i == 0);
            @(negedge clk);
        end
        set_idle();
        @(negedge clk);
        n_checks++;
        if (a_pkt_cnt0 !== 32'd1 || a_drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL rstmid_pre: got pkt0=%0d drop=%0d want 1/1", a_pkt_cnt0, a_drop_cnt);
        end
        in0_req = 1; in1_req = 1;
        cyc = 0;
        while (a_in0_grant !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 5; i++) begin
            in0_data = make_flit(hdr_of(i, 8), i, 0); in0_data_wr = 1;
            if (i == 4) rst = 1;
            @(negedge clk);
        end
        n_checks++;
        if ({a_in0_grant, a_in1_grant, a_out_wr, a_out_valid, a_out_valid_wr} !== 5'b0 || a_out_data !== 134'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got g0=%b g1=%b wr=%b d=%h want all 0",
                a_in0_grant, a_in1_grant, a_out_wr, a_out_data);
        end
        n_checks++;
        if ({a_pkt_cnt0, a_pkt_cnt1, a_drop_cnt, a_timeout_cnt} !== 96'd0) begin
            n_fail++; $display("FAIL rstmid_counters: got %h want 0", {a_pkt_cnt0, a_pkt_cnt1, a_drop_cnt, a_timeout_cnt});
        end
        rst = 0; set_idle();
        cyc = 0;
        while (a_in0_grant !== 1'b1 && a_in1_grant !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        n_checks++;
        if (a_in0_grant !== 1'b1 || a_in1_grant !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_first_grant: got g0=%b g1=%b want g0=1 g1=0", a_in0_grant, a_in1_grant);
        end
        in0_req = 0; in1_req = 0;
    endtask

    initial begin
        rst = 1; in0_req = 0; in1_req = 0; pkt_len = 3;
        src0_idx = 0; src1_idx = 0;
        set_idle();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_priority();
        test_timeout();
        test_drop();
        test_bad_header();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
